// File: rtl/stacker_pkg.sv
// Shared DRAM-path constants and the byte-strobe helper used by the
// stacker (write side) and the unstacker (read side).
package stacker_pkg;

    localparam int WORD_W           = 16;
    localparam int PHRASE_W         = 128;
    localparam int WORDS_PER_PHRASE = PHRASE_W / WORD_W;
    localparam int STRB_W           = PHRASE_W / 8;
    localparam int BYTES_PER_WORD   = WORD_W / 8;
    localparam int IDX_W            = $clog2(WORDS_PER_PHRASE);

    // Byte mask covering words 0..idx of a phrase (idx+1 valid words).
    function automatic logic [STRB_W-1:0] strb_for(input logic [IDX_W-1:0] idx);
        logic [STRB_W-1:0] mask;
        mask = '0;
        for (int w = 0; w < WORDS_PER_PHRASE; w++) begin
            if (w <= int'(idx)) begin
                mask[w*BYTES_PER_WORD +: BYTES_PER_WORD] = '1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/stacker_if.sv
// Pixel-in / chunk-out stream bundle for the stacker. The master side
// produces pixels and consumes chunks; the slave side is the stacker.
interface stacker_if #(
    parameter int WORD_W   = 16,
    parameter int PHRASE_W = 128
);

    logic                  pixel_tvalid;
    logic                  pixel_tready;
    logic [WORD_W-1:0]     pixel_tdata;
    logic                  pixel_tlast;

    logic                  chunk_tvalid;
    logic                  chunk_tready;
    logic [PHRASE_W-1:0]   chunk_tdata;
    logic [PHRASE_W/8-1:0] chunk_tstrb;
    logic                  chunk_tlast;

    modport master (
        output pixel_tvalid, pixel_tdata, pixel_tlast, chunk_tready,
        input  pixel_tready, chunk_tvalid, chunk_tdata, chunk_tstrb, chunk_tlast
    );

    modport slave (
        input  pixel_tvalid, pixel_tdata, pixel_tlast, chunk_tready,
        output pixel_tready, chunk_tvalid, chunk_tdata, chunk_tstrb, chunk_tlast
    );

endinterface

// File: rtl/stacker.sv
// Packs 16-bit pixel words into 128-bit DRAM phrases, word 0 in the low
// bits. A pixel_tlast closes the phrase early with zero padding and a
// partial byte strobe. A single output register holds the finished phrase.
module stacker
    import stacker_pkg::*;
#(
    parameter int WORD_W   = stacker_pkg::WORD_W,
    parameter int PHRASE_W = stacker_pkg::PHRASE_W,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    stacker_if.slave         bus,
    output logic [CNT_W-1:0] phrase_count
);

    localparam int N = PHRASE_W / WORD_W;

    logic [PHRASE_W-1:0]   asm_data;
    logic [IDX_W-1:0]      idx;
    logic [PHRASE_W-1:0]   merged;

    logic                  out_valid;
    logic [PHRASE_W-1:0]   out_data;
    logic [PHRASE_W/8-1:0] out_strb;
    logic                  out_last;

    logic                  ready;
    logic                  accept_in;
    logic                  accept_out;
    logic                  complete;

    // Input is held off only while a finished phrase is stuck downstream.
    assign ready      = !out_valid || bus.chunk_tready;
    assign accept_in  = bus.pixel_tvalid && ready;
    assign accept_out = out_valid && bus.chunk_tready;
    assign complete   = (idx == IDX_W'(N - 1)) || bus.pixel_tlast;

    assign bus.pixel_tready = ready;
    assign bus.chunk_tvalid = out_valid;
    assign bus.chunk_tdata  = out_data;
    assign bus.chunk_tstrb  = out_strb;
    assign bus.chunk_tlast  = out_last;

    // Phrase as it would look if closed by the current word: that word at
    // idx, everything above it zeroed.
    always_comb begin
        merged = asm_data;
        for (int i = 0; i < N; i++) begin
            if (IDX_W'(i) == idx) begin
                merged[i*WORD_W +: WORD_W] = bus.pixel_tdata;
            end else if (IDX_W'(i) > idx) begin
                merged[i*WORD_W +: WORD_W] = '0;
            end
        end
    end

    // Assembly register: collect words, clear once a phrase is handed off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_data <= '0;
            idx      <= '0;
        end else if (accept_in) begin
            if (complete) begin
                asm_data <= '0;
                idx      <= '0;
            end else begin
                asm_data[idx*WORD_W +: WORD_W] <= bus.pixel_tdata;
                idx                            <= idx + 1'b1;
            end
        end
    end

    // Output register: a completion load takes priority over the drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_strb  <= '0;
            out_last  <= 1'b0;
        end else if (accept_in && complete) begin
            out_valid <= 1'b1;
            out_data  <= merged;
            out_strb  <= strb_for(idx);
            out_last  <= bus.pixel_tlast;
        end else if (accept_out) begin
            out_valid <= 1'b0;
        end
    end

    // Count phrases taken by the downstream FIFO; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phrase_count <= '0;
        end else if (accept_out) begin
            phrase_count <= phrase_count + 1'b1;
        end
    end

endmodule
